// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down counter with a programmable
// modulus (0..MAX_VAL), an enable prescaler, parallel load, synchronous
// clear and a choice of wrap or saturate at the boundaries.
// Registered terminal-count pulse (tc) and sticky boundary flag.
//
// Optional build macro: COUNTER_SNAPSHOT_EN
//   When defined, this adds input snap and output snap_count. snap_count
//   captures the pre-edge count whenever snap=1. Only reset clears it.
module mod_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = 7,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
`ifdef COUNTER_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_count,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf_sticky
);

  localparam logic [WIDTH:0]   max_ext  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] max_w    = WIDTH'(MAX_VAL);
  localparam logic [15:0]      psc_last = 16'(PRESCALE - 1);

  logic [15:0]      psc;
  logic             step;
  logic             boundary;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] ld_clamped;

  assign step = en && (psc == psc_last);

  // Next count for a step, plus boundary detection. The extra bit catches
  // overflow past MAX_VAL going up. It also shows the borrow out of 0 going down.
  always_comb begin
    cnt_ext  = {1'b0, count};
    sum_ext  = cnt_ext + (WIDTH+1)'(1);
    dif_ext  = cnt_ext - (WIDTH+1)'(1);
    boundary = 1'b0;
    cnt_nxt  = count;
    if (up) begin
      if (sum_ext > max_ext) begin
        boundary = 1'b1;
        cnt_nxt  = (SATURATE != 0) ? max_w : '0;
      end else begin
        cnt_nxt  = sum_ext[WIDTH-1:0];
      end
    end else begin
      if (dif_ext[WIDTH]) begin
        boundary = 1'b1;
        cnt_nxt  = (SATURATE != 0) ? '0 : max_w;
      end else begin
        cnt_nxt  = dif_ext[WIDTH-1:0];
      end
    end
  end

  // Clamp parallel-load values that lie above the modulus.
  always_comb begin
    ld_ext     = {1'b0, load_val};
    ld_clamped = (ld_ext > max_ext) ? max_w : load_val;
  end

  // Counter, prescaler and flags, with priority reset > clear > load > step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      psc        <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      psc        <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      count      <= ld_clamped;
      psc        <= '0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (step) begin
        psc   <= '0;
        count <= cnt_nxt;
        if (boundary) begin
          tc         <= 1'b1;
          ovf_sticky <= 1'b1;
        end
      end else if (en) begin
        psc <= psc + 16'd1;
      end
    end
  end

`ifdef COUNTER_SNAPSHOT_EN
  // Snapshot of the pre-edge count. clear and load leave it alone.
  always_ff @(posedge clk) begin
    if (reset)
      snap_count <= '0;
    else if (snap)
      snap_count <= count;
  end
`endif

  assign at_max = (count == max_w);
  assign at_min = (count == '0);

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised up/down counter with programmable modulus, enable prescaler, parallel load, synchronous clear and wrap/saturate mode. It replaces the fixed 3-bit free-running counter as the general-purpose counting primitive for timers, sequencers and display multiplexing in the lab designs. It produces registered terminal-count and boundary flags for downstream FSMs.

Parameters:
WIDTH, 3, counter width in bits (1..32)
MAX_VAL, 7, highest count value; range is 0..MAX_VAL; must satisfy MAX_VAL <= 2^WIDTH-1
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries
PRESCALE, 1, number of enabled cycles per count step (1..65535); 1 = step every enabled cycle

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; advances the prescaler when high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
clear  input  1  synchronous clear of count, prescaler and sticky flag
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle registered pulse: the previous cycle's step hit a boundary
at_max  output  1  count == MAX_VAL (combinational from the count register)
at_min  output  1  count == 0 (combinational from the count register)
ovf_sticky  output  1  set on any boundary event; cleared only by reset or clear

Behaviour:
- Reset values: count=0, prescaler=0, tc=0, ovf_sticky=0; at_min=1, at_max=(MAX_VAL==0).
- Priority per clock edge: reset > clear > load > step. Lower-priority actions are ignored in that cycle.
- clear: count=0, prescaler=0, ovf_sticky=0, tc=0 on the next edge.
- load: count=min(load_val, MAX_VAL), prescaler=0, tc=0. ovf_sticky is unchanged.
- Prescaler: a 16-bit internal counter that advances only when en=1.
- step = en && (prescaler == PRESCALE-1). When step is asserted, the prescaler returns to 0. When en=0, the prescaler holds its value.
- A step with up=1:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: becomes 0 if SATURATE=0, stays MAX_VAL if SATURATE=1. Either case is a boundary event.
- A step with up=0:
  - count > 0: count-1.
  - count == 0: becomes MAX_VAL if SATURATE=0, stays 0 if SATURATE=1. Either case is a boundary event.
- Boundary event: tc=1 for exactly the next cycle and ovf_sticky is set. Latency is 1 cycle from the stepping edge. Back-to-back events keep tc high on consecutive cycles.
- up is sampled only on step cycles. A direction change takes effect on the next step and causes no boundary event by itself.
- MAX_VAL=0: every step is a boundary event and count stays 0.
- Arithmetic is computed at WIDTH+1 bits internally. count never leaves 0..MAX_VAL, including when load_val is out of range.
- When reset is asserted mid-prescale or mid-count, every register goes to its reset value on that edge. There is no partial state.

Optional Feature:
COUNTER_SNAPSHOT_EN
- Defined: adds input snap (1 bit) and output snap_count (WIDTH bits).
  - On an edge where snap=1, snap_count captures the pre-edge value of count. It holds otherwise.
  - snap_count is reset to 0 by reset only; clear does not affect it.
  - If snap and load occur in the same cycle, snap captures the old count.
- Undefined: neither port exists, and count behaviour is identical.

Test Plan:
1. Wrap up: WIDTH=3, MAX_VAL=5, SATURATE=0, PRESCALE=1, en=1, up=1 from reset -> count 0,1,2,3,4,5,0. tc is high only in the cycle count shows 0 after 5, and ovf_sticky=1 from then on.
2. Saturate down: SATURATE=1, load_val=2 then up=0, en=1 -> count 2,1,0,0,0. tc pulses on each step at 0, at_min=1, count never becomes 5.
3. Prescale: PRESCALE=3, en=1, up=1 -> count increments every 3rd cycle (0,0,0,1,1,1,2). Dropping en for 4 cycles mid-period freezes both count and phase.
4. Load clamp and priority: MAX_VAL=5, load=1 with load_val=7 -> count=5, at_max=1. load and clear in the same cycle -> count=0. reset together with clear/load -> all outputs at reset values.
5. Direction flip at boundary: count=5, up=1 step -> 0 with tc. Next step up=0 -> 5 with tc. ovf_sticky stays 1 until clear, then reads 0.
6. Snapshot (with COUNTER_SNAPSHOT_EN): count=3, snap=1 and load_val=1 with load=1 in the same cycle -> snap_count=3, count=1. A clear afterwards leaves snap_count=3.
